// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared 640x480@60 timing constants, total derivation and pixel type
package vga_pkg;

  localparam int CNT_W = 10;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;

  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // Period of one axis: visible span plus front porch, sync and back porch.
  function automatic int calc_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  localparam int DEF_H_TOTAL = calc_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);  // 800
  localparam int DEF_V_TOTAL = calc_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);  // 525

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb24_t;

endpackage

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - free-running h/v counters with active, sync and frame-start decode
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             active,
  output logic             hsync,
  output logic             vsync,
  output logic             frame_start
);

  localparam int H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [CNT_W-1:0] H_MAX        = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_MAX        = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_END    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_END    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] H_SYNC_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SYNC_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SYNC_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  // Horizontal counter wraps every line; vertical advances on each horizontal wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_MAX) begin
      h_cnt <= '0;
      if (v_cnt == V_MAX) begin
        v_cnt <= '0;
      end else begin
        v_cnt <= v_cnt + 1'b1;
      end
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  // Region decode straight from the counter values; syncs are active low.
  always_comb begin
    active      = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
    hsync       = !((h_cnt >= H_SYNC_START) && (h_cnt < H_SYNC_END));
    vsync       = !((v_cnt >= V_SYNC_START) && (v_cnt < V_SYNC_END));
    frame_start = (h_cnt == '0) && (v_cnt == '0);
  end

endmodule

// File: rtl/vga_ctrl.sv
// rtl/vga_ctrl.sv - VGA address/data pipeline; VGA_CTRL_PIPE_EN adds a stage for synchronous-read memory
module vga_ctrl
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [23:0]      vga_data,
  output logic [CNT_W-1:0] h_addr,
  output logic [CNT_W-1:0] v_addr,
  output logic             frame_tick,
  output logic             VGA_HSYNC,
  output logic             VGA_VSYNC,
  output logic             VGA_BLANK_N,
  output logic [7:0]       VGA_R,
  output logic [7:0]       VGA_G,
  output logic [7:0]       VGA_B
);

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             t_active;
  logic             t_hsync;
  logic             t_vsync;
  logic             t_frame_start;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk         (clk),
    .rst         (rst),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .active      (t_active),
    .hsync       (t_hsync),
    .vsync       (t_vsync),
    .frame_start (t_frame_start)
  );

  logic s1_active;
  logic s1_hsync;
  logic s1_vsync;

  // Address stage: issue the memory address (zero in blanking) and carry the region flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_addr     <= '0;
      v_addr     <= '0;
      frame_tick <= 1'b0;
      s1_active  <= 1'b0;
      s1_hsync   <= 1'b1;
      s1_vsync   <= 1'b1;
    end else begin
      h_addr     <= t_active ? h_cnt : '0;
      v_addr     <= t_active ? v_cnt : '0;
      frame_tick <= t_frame_start;
      s1_active  <= t_active;
      s1_hsync   <= t_hsync;
      s1_vsync   <= t_vsync;
    end
  end

  logic px_active;
  logic px_hsync;
  logic px_vsync;

`ifdef VGA_CTRL_PIPE_EN
  // Memory read data lags the address by a cycle, so the flags wait one more cycle to match.
  always_ff @(posedge clk) begin
    if (rst) begin
      px_active <= 1'b0;
      px_hsync  <= 1'b1;
      px_vsync  <= 1'b1;
    end else begin
      px_active <= s1_active;
      px_hsync  <= s1_hsync;
      px_vsync  <= s1_vsync;
    end
  end
`else
  // Asynchronous-read memory returns data in the address cycle; flags pass straight through.
  always_comb begin
    px_active = s1_active;
    px_hsync  = s1_hsync;
    px_vsync  = s1_vsync;
  end
`endif

  rgb24_t pix;
  assign pix = vga_data;

  // Output stage: colour, blank and syncs all register on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      VGA_R       <= 8'h00;
      VGA_G       <= 8'h00;
      VGA_B       <= 8'h00;
      VGA_BLANK_N <= 1'b0;
      VGA_HSYNC   <= 1'b1;
      VGA_VSYNC   <= 1'b1;
    end else begin
      VGA_R       <= px_active ? pix.r : 8'h00;
      VGA_G       <= px_active ? pix.g : 8'h00;
      VGA_B       <= px_active ? pix.b : 8'h00;
      VGA_BLANK_N <= px_active;
      VGA_HSYNC   <= px_hsync;
      VGA_VSYNC   <= px_vsync;
    end
  end

endmodule

// File: tb/tb_vga_ctrl.sv
// tb/tb_vga_ctrl.sv - directed bench for vga_ctrl on a reduced 64x24 raster; VGA_CTRL_PIPE_EN selects registered memory
`timescale 1ns/1ps
module tb_vga_ctrl;

  // Reduced raster keeps several full frames inside a short run.
  localparam int HA = 64, HF = 4, HS = 8, HB = 4;
  localparam int VA = 24, VF = 2, VS = 2, VB = 3;
  localparam int HT    = 80;    // 64+4+8+4
  localparam int VT    = 31;    // 24+2+2+3
  localparam int FRAME = 2480;  // 80*31
  localparam int HS_START = 68; // 64+4
  localparam int VS_START = 26; // 24+2

`ifdef VGA_CTRL_PIPE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] vga_data;
  logic [9:0]  h_addr;
  logic [9:0]  v_addr;
  logic        frame_tick;
  logic        VGA_HSYNC;
  logic        VGA_VSYNC;
  logic        VGA_BLANK_N;
  logic [7:0]  VGA_R;
  logic [7:0]  VGA_G;
  logic [7:0]  VGA_B;

  logic        force_ff = 1'b0;
  logic [23:0] mem_word;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;

`ifdef VGA_CTRL_PIPE_EN
  always @(posedge clk) mem_word <= {h_addr[7:0], v_addr[7:0], 8'hA5};
`else
  assign mem_word = {h_addr[7:0], v_addr[7:0], 8'hA5};
`endif
  assign vga_data = force_ff ? 24'hFFFFFF : mem_word;

  vga_ctrl #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .vga_data    (vga_data),
    .h_addr      (h_addr),
    .v_addr      (v_addr),
    .frame_tick  (frame_tick),
    .VGA_HSYNC   (VGA_HSYNC),
    .VGA_VSYNC   (VGA_VSYNC),
    .VGA_BLANK_N (VGA_BLANK_N),
    .VGA_R       (VGA_R),
    .VGA_G       (VGA_G),
    .VGA_B       (VGA_B)
  );

  // cyc counts cycles since the cycle in which the counter held (0,0).
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    n_tests++;
    if ({VGA_HSYNC, VGA_VSYNC, VGA_BLANK_N} !== 3'b110) begin
      n_fail++;
      $display("FAIL %s_sync_blank: got %b expected 110", tag, {VGA_HSYNC, VGA_VSYNC, VGA_BLANK_N});
    end
    n_tests++;
    if ({VGA_R, VGA_G, VGA_B} !== 24'h000000) begin
      n_fail++;
      $display("FAIL %s_rgb: got %h expected 000000", tag, {VGA_R, VGA_G, VGA_B});
    end
    n_tests++;
    if ({h_addr, v_addr, frame_tick} !== 21'd0) begin
      n_fail++;
      $display("FAIL %s_addr: got h=%0d v=%0d tick=%b expected 0 0 0", tag, h_addr, v_addr, frame_tick);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_reset_outputs("reset");
    end
    rst = 1'b0;
    cyc = 0;
    tick();
    n_tests++;
    if ({frame_tick, h_addr, v_addr} !== {1'b1, 10'd0, 10'd0}) begin
      n_fail++;
      $display("FAIL reset_first_tick: got tick=%b h=%0d v=%0d expected 1 0 0", frame_tick, h_addr, v_addr);
    end
    tick();
    n_tests++;
    if ({frame_tick, h_addr, v_addr} !== {1'b0, 10'd1, 10'd0}) begin
      n_fail++;
      $display("FAIL reset_second_addr: got tick=%b h=%0d v=%0d expected 0 1 0", frame_tick, h_addr, v_addr);
    end
  endtask

  // Line 0 of the frame: outputs in cycles [LAT, LAT+HT).
  task automatic test_line();
    int   fall = -1;
    int   low  = 0;
    int   vis  = 0;
    logic prev_hs = 1'b1;
    while (cyc < LAT + HT) begin
      if (cyc >= LAT) begin
        if (VGA_BLANK_N === 1'b1) vis++;
        if (VGA_HSYNC === 1'b0) low++;
        if (prev_hs === 1'b1 && VGA_HSYNC === 1'b0 && fall < 0) fall = cyc;
      end
      prev_hs = VGA_HSYNC;
      tick();
    end
    n_tests++;
    if (fall !== HS_START + LAT) begin
      n_fail++;
      $display("FAIL line_hsync_fall: got %0d expected %0d", fall, HS_START + LAT);
    end
    n_tests++;
    if (low !== 8) begin
      n_fail++;
      $display("FAIL line_hsync_width: got %0d expected 8", low);
    end
    n_tests++;
    if (vis !== 64) begin
      n_fail++;
      $display("FAIL line_blank_n_width: got %0d expected 64", vis);
    end
  endtask

  // Frame 1 outputs occupy cycles [FRAME+LAT, 2*FRAME+LAT).
  task automatic test_frame();
    int   t1 = -1, t2 = -1, ticks = 0;
    int   vlow = 0, vfall = -1, hlow = 0, vis = 0;
    logic prev_vs = 1'b1;
    while (cyc <= 2 * FRAME + LAT) begin
      if (frame_tick === 1'b1) begin
        ticks++;
        if (t1 < 0) t1 = cyc;
        else if (t2 < 0) t2 = cyc;
      end
      if (cyc >= FRAME + LAT && cyc < 2 * FRAME + LAT) begin
        if (VGA_VSYNC === 1'b0) vlow++;
        if (VGA_HSYNC === 1'b0) hlow++;
        if (VGA_BLANK_N === 1'b1) vis++;
        if (prev_vs === 1'b1 && VGA_VSYNC === 1'b0 && vfall < 0) vfall = cyc;
      end
      prev_vs = VGA_VSYNC;
      tick();
    end
    n_tests++;
    if (ticks !== 2 || t1 !== FRAME + 1) begin
      n_fail++;
      $display("FAIL frame_tick_place: got count=%0d first=%0d expected 2 %0d", ticks, t1, FRAME + 1);
    end
    n_tests++;
    if (t2 - t1 !== FRAME) begin
      n_fail++;
      $display("FAIL frame_tick_period: got %0d expected %0d", t2 - t1, FRAME);
    end
    n_tests++;
    if (vlow !== 160) begin
      n_fail++;
      $display("FAIL frame_vsync_width: got %0d expected 160", vlow);
    end
    n_tests++;
    if (vfall !== FRAME + VS_START * HT + LAT) begin
      n_fail++;
      $display("FAIL frame_vsync_fall: got %0d expected %0d", vfall, FRAME + VS_START * HT + LAT);
    end
    n_tests++;
    if (hlow !== 248) begin
      n_fail++;
      $display("FAIL frame_hsync_total: got %0d expected 248", hlow);
    end
    n_tests++;
    if (vis !== 1536) begin
      n_fail++;
      $display("FAIL frame_visible_total: got %0d expected 1536", vis);
    end
  endtask

  task automatic test_pixel();
    int base;
    base = 2 * FRAME + 7 * HT + 3;  // counter (3,7) in frame 2
    run_to(base + 1);
    n_tests++;
    if ({h_addr, v_addr} !== {10'd3, 10'd7}) begin
      n_fail++;
      $display("FAIL pixel_addr: got h=%0d v=%0d expected 3 7", h_addr, v_addr);
    end
    run_to(base + LAT - 1);
    n_tests++;
    if ({VGA_R, VGA_G, VGA_B} !== 24'h0207A5) begin
      n_fail++;
      $display("FAIL pixel_prev: got %h expected 0207a5", {VGA_R, VGA_G, VGA_B});
    end
    run_to(base + LAT);
    n_tests++;
    if ({VGA_BLANK_N, VGA_R, VGA_G, VGA_B} !== {1'b1, 24'h0307A5}) begin
      n_fail++;
      $display("FAIL pixel_3_7: got blank_n=%b rgb=%h expected 1 0307a5", VGA_BLANK_N, {VGA_R, VGA_G, VGA_B});
    end
    run_to(2 * FRAME + 20 * HT + 60 + LAT);
    n_tests++;
    if ({VGA_R, VGA_G, VGA_B} !== 24'h3C14A5) begin
      n_fail++;
      $display("FAIL pixel_60_20: got %h expected 3c14a5", {VGA_R, VGA_G, VGA_B});
    end
  endtask

  task automatic test_blanking();
    int c;
    force_ff = 1'b1;
    c = 3 * FRAME + 8 * HT + 5;  // visible (5,8)
    run_to(c + LAT);
    n_tests++;
    if ({VGA_BLANK_N, VGA_R, VGA_G, VGA_B} !== {1'b1, 24'hFFFFFF}) begin
      n_fail++;
      $display("FAIL blank_visible_ff: got blank_n=%b rgb=%h expected 1 ffffff", VGA_BLANK_N, {VGA_R, VGA_G, VGA_B});
    end
    c = 3 * FRAME + 8 * HT + 70;  // horizontal blanking (70,8)
    run_to(c + 1);
    n_tests++;
    if ({h_addr, v_addr} !== 20'd0) begin
      n_fail++;
      $display("FAIL blank_h_addr: got h=%0d v=%0d expected 0 0", h_addr, v_addr);
    end
    run_to(c + LAT);
    n_tests++;
    if ({VGA_BLANK_N, VGA_R, VGA_G, VGA_B} !== 25'd0) begin
      n_fail++;
      $display("FAIL blank_h_rgb: got blank_n=%b rgb=%h expected 0 000000", VGA_BLANK_N, {VGA_R, VGA_G, VGA_B});
    end
    c = 3 * FRAME + 25 * HT + 10;  // vertical blanking (10,25)
    run_to(c + 1);
    n_tests++;
    if ({h_addr, v_addr} !== 20'd0) begin
      n_fail++;
      $display("FAIL blank_v_addr: got h=%0d v=%0d expected 0 0", h_addr, v_addr);
    end
    run_to(c + LAT);
    n_tests++;
    if ({VGA_BLANK_N, VGA_R, VGA_G, VGA_B} !== 25'd0) begin
      n_fail++;
      $display("FAIL blank_v_rgb: got blank_n=%b rgb=%h expected 0 000000", VGA_BLANK_N, {VGA_R, VGA_G, VGA_B});
    end
    force_ff = 1'b0;
  endtask

  task automatic test_mid_reset();
    run_to(4 * FRAME + 12 * HT + 32);  // counter (32,12)
    rst = 1'b1;
    tick();
    check_reset_outputs("midrst");
    rst = 1'b0;
    cyc = 0;
    tick();
    n_tests++;
    if ({frame_tick, h_addr, v_addr} !== {1'b1, 10'd0, 10'd0}) begin
      n_fail++;
      $display("FAIL midrst_restart: got tick=%b h=%0d v=%0d expected 1 0 0", frame_tick, h_addr, v_addr);
    end
    test_line();
    test_frame();
  endtask

  initial begin
    test_reset();
    test_line();
    test_frame();
    test_pixel();
    test_blanking();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_ctrl.md
# vga_ctrl

- VGA timing controller that sequences the frame-buffer read path.
- A free-running horizontal/vertical counter pair drives the pixel read address (`h_addr`, `v_addr`) into the video memory.
- The returned `vga_data` is registered and gated by blanking, and leaves the block as RGB. `VGA_HSYNC`, `VGA_VSYNC` and `VGA_BLANK_N` are delayed so they stay aligned with the pixel.
- Sits in `top` between the pixel clock and the `vmem` instance. `VGA_CLK` stays wired to `clk` in `top`.

## Interface

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch

Ports:
- clk  in  1  pixel clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- vga_data  in  24  pixel from memory, {R[23:16], G[15:8], B[7:0]}
- h_addr  out  10  pixel column to memory
- v_addr  out  10  pixel row to memory
- frame_tick  out  1  one-cycle pulse, address of pixel (0,0) issued
- VGA_HSYNC  out  1  horizontal sync, active low
- VGA_VSYNC  out  1  vertical sync, active low
- VGA_BLANK_N  out  1  high while the presented pixel is visible
- VGA_R / VGA_G / VGA_B  out  8 each  pixel colour

## Operation

Counters:
- h_cnt runs 0..H_TOTAL-1, where H_TOTAL = 800. It wraps to 0.
- v_cnt increments when h_cnt wraps and runs 0..V_TOTAL-1, where V_TOTAL = 525. It wraps to 0 when both counters are at maximum.
- Counter regions:
  - Active region: h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
  - Sync asserted (low) for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - Same rule applies vertically.

Address stage (S1, registered from counters):
- h_addr = h_cnt and v_addr = v_cnt while active.
- Both are 0 outside the active region.
- frame_tick = 1 when h_cnt == 0 and v_cnt == 0.
- Active, hsync and vsync flags are carried alongside.

Output stage (S2):
- VGA_R/G/B = vga_data split when the carried active flag is 1, else 0.
- VGA_BLANK_N = carried active flag.
- VGA_HSYNC and VGA_VSYNC = carried sync flags.

Width rule:
- Counters are 10 bits.
- Comparisons are unsigned against parameter sums computed as localparams.

Reset:
- Counters = 0.
- h_addr = 0, v_addr = 0, frame_tick = 0.
- VGA_HSYNC = 1, VGA_VSYNC = 1, VGA_BLANK_N = 0, RGB = 0.
- Asserting rst mid-frame takes effect on the next edge. The frame restarts at (0,0) the first cycle after release, with no partial sync pulse held over.

## Timing

- vga_data is combinational in h_addr/v_addr (asynchronous-read memory).
- Counter value N appears on address outputs one cycle later.
- The matching pixel and syncs appear two cycles after counter value N.
- Pixel, VGA_BLANK_N, VGA_HSYNC and VGA_VSYNC always change on the same edge.
- frame_tick is aligned with S1, i.e. with h_addr=0, v_addr=0 of the first visible pixel.
- Line period is 800 cycles; frame period is 420000 cycles.
- HSYNC low for 96 cycles per line.
- VSYNC low for 2 × 800 = 1600 cycles per frame.

## Configuration

- `VGA_CTRL_PIPE_EN` defined:
  - One extra register stage is inserted between S1 and S2 for synchronous-read memory: vga_data is sampled one cycle after the address.
  - The active/sync flags get one more delay stage.
  - Counter-to-pixel latency becomes 3 cycles.
  - frame_tick timing is unchanged.
  - The extra stage resets to blank/inactive values (syncs 1, blank_n 0).
- Undefined: 2-cycle latency as above.

## Structure

- Shared package `vga_pkg`:
  - default 640×480@60 timing constants
  - H_TOTAL/V_TOTAL derivation
  - rgb24 typedef
- One sub-module, `vga_timing`:
  - counters plus region decode (active, hsync, vsync, frame start)
  - instanced once
- `vga_ctrl` holds the address/data pipeline.

## Test plan

1. Reset held 5 cycles, then released:
   - during reset, outputs are at reset values
   - first cycle after release: counter (0,0)
   - next edge: frame_tick = 1, h_addr = 0, v_addr = 0
2. Free run one line:
   - VGA_HSYNC falls exactly 656 + 2 cycles after the line's counter 0
   - it stays low 96 cycles
   - VGA_BLANK_N is high for exactly 640 cycles
3. Free run one frame:
   - VSYNC low for 1600 cycles starting at line 490
   - frame_tick period is 420000 cycles
4. Memory model returning {h_addr[7:0], v_addr[7:0], 8'hA5}:
   - pixel (3,7) shows R=03, G=07, B=A5, two cycles after its counter value
   - three cycles when `VGA_CTRL_PIPE_EN` is defined, using a registered memory model
5. During blanking (e.g. h_cnt 700), memory forced to FFFFFF:
   - RGB = 0
   - h_addr = 0
6. rst pulsed one cycle at (320,240):
   - next cycle outputs are at reset values
   - after release the counter restarts at (0,0)
   - the next full frame timing matches scenario 3
